// File: rtl/hcsr04_ranger.sv
// HC-SR04 ultrasonic ranger: trigger pulse, echo synchronisation and timing, echo width to cm.
// Optional macro HCSR04_CONTINUOUS_EN: free-running measurements after the first start.
module hcsr04_ranger #(
  parameter int unsigned CLK_FREQ_HZ  = 50_000_000,
  parameter int unsigned TRIG_US      = 10,
  parameter int unsigned ECHO_WAIT_US = 2_000,
  parameter int unsigned ECHO_MAX_US  = 38_000,
  parameter int unsigned HOLDOFF_US   = 50_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       echo,
  output logic       trig,
  output logic [7:0] distancia_cm,
  output logic       valid,
  output logic       timeout,
  output logic       busy
);

  localparam int unsigned CYC_US        = CLK_FREQ_HZ / 1_000_000;
  localparam int unsigned CYCLES_PER_CM = CYC_US * 58;

  localparam logic [31:0] TRIG_LAST = 32'(TRIG_US * CYC_US - 1);
  localparam logic [31:0] WAIT_LAST = 32'(ECHO_WAIT_US * CYC_US - 1);
  localparam logic [31:0] MAX_LAST  = 32'(ECHO_MAX_US * CYC_US - 1);
  localparam logic [31:0] HOLD_LAST = 32'(HOLDOFF_US * CYC_US - 1);
  localparam logic [31:0] SUB_LAST  = 32'(CYCLES_PER_CM - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_ECHO = 3'd2,
    MEASURE   = 3'd3,
    HOLDOFF   = 3'd4
  } state_t;

  state_t      state;
  logic [31:0] cnt;
  logic [31:0] sub;
  logic [7:0]  cm_acc;

  logic echo_p0;
  logic echo_s;
  logic echo_s_p1;
  logic echo_rise;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Stage p0 -> echo_s: two-flop synchroniser; echo_s_p1 is the copy used for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_p0   <= 1'b0;
      echo_s    <= 1'b0;
      echo_s_p1 <= 1'b0;
    end else begin
      echo_p0   <= echo;
      echo_s    <= echo_p0;
      echo_s_p1 <= echo_s;
    end
  end

  // A sensor stuck high on WAIT_ECHO entry never produces a rise, so it ends in timeout
  assign echo_rise = echo_s & ~echo_s_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      trig         <= 1'b0;
      valid        <= 1'b0;
      timeout      <= 1'b0;
      busy         <= 1'b0;
      distancia_cm <= 8'hFF;
      cnt          <= '0;
      sub          <= '0;
      cm_acc       <= '0;
    end else begin
      valid   <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= TRIG;
            trig   <= 1'b1;
            busy   <= 1'b1;
            cnt    <= '0;
            sub    <= '0;
            cm_acc <= '0;
          end
        end
        TRIG: begin
          if (cnt == TRIG_LAST) begin
            trig  <= 1'b0;
            state <= WAIT_ECHO;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        WAIT_ECHO: begin
          if (echo_rise) begin
            // The rise cycle is already echo cycle 1
            state  <= MEASURE;
            cnt    <= 32'd1;
            sub    <= (SUB_LAST == 32'd0) ? 32'd0 : 32'd1;
            cm_acc <= (SUB_LAST == 32'd0) ? 8'd1 : 8'd0;
          end else if (cnt == WAIT_LAST) begin
            timeout      <= 1'b1;
            distancia_cm <= 8'hFF;
            state        <= HOLDOFF;
            cnt          <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        MEASURE: begin
          if (!echo_s) begin
            distancia_cm <= cm_acc;
            valid        <= 1'b1;
            state        <= HOLDOFF;
            cnt          <= '0;
          end else if (cnt == MAX_LAST) begin
            timeout      <= 1'b1;
            distancia_cm <= 8'hFF;
            state        <= HOLDOFF;
            cnt          <= '0;
          end else begin
            cnt <= cnt + 32'd1;
            if (sub == SUB_LAST) begin
              sub    <= '0;
              cm_acc <= sat_inc8(cm_acc);
            end else begin
              sub <= sub + 32'd1;
            end
          end
        end
        HOLDOFF: begin
          // Quiet time only starts once the echo line has returned low
          if (echo_s) begin
            cnt <= '0;
          end else if (cnt == HOLD_LAST) begin
            cnt <= '0;
`ifdef HCSR04_CONTINUOUS_EN
            state  <= TRIG;
            trig   <= 1'b1;
            sub    <= '0;
            cm_acc <= '0;
`else
            state <= IDLE;
            busy  <= 1'b0;
`endif
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: begin
          state <= IDLE;
          trig  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hcsr04_ranger.sv
// Directed bench for hcsr04_ranger at 1 MHz (58 cycles per cm), single-shot build.
module tb_hcsr04_ranger;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       echo;
  logic       trig;
  logic [7:0] distancia_cm;
  logic       valid;
  logic       timeout;
  logic       busy;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int trig_rises = 0;

  hcsr04_ranger #(
    .CLK_FREQ_HZ (1_000_000),
    .TRIG_US     (10),
    .ECHO_WAIT_US(200),
    .ECHO_MAX_US (2000),
    .HOLDOFF_US  (100)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .echo        (echo),
    .trig        (trig),
    .distancia_cm(distancia_cm),
    .valid       (valid),
    .timeout     (timeout),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge trig) trig_rises++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts trig-high samples starting at the current cycle; ends on the first WAIT_ECHO cycle.
  task automatic trig_width(output int n);
    n = 0;
    while (trig === 1'b1 && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic run_meas(input int width, input logic [7:0] exp_cm, input string tag);
    int n;
    pulse_start();
    check({tag, "_busy"}, busy, 1);
    trig_width(n);
    check({tag, "_trig_w"}, n, 10);
    repeat (49) tick();
    echo = 1'b1;
    repeat (width) tick();
    echo = 1'b0;
    n = 0;
    while (valid !== 1'b1 && timeout !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_valid_lat"}, n, 3);
    check({tag, "_valid"}, valid, 1);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_cm"}, distancia_cm, exp_cm);
    tick();
    check({tag, "_valid_1cyc"}, valid, 0);
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_holdoff"}, n, 99);
    check({tag, "_cm_held"}, distancia_cm, exp_cm);
  endtask

  initial begin
    int n;
    int m;
    int rises0;
    rst_n = 1'b0;
    start = 1'b0;
    echo  = 1'b0;
    repeat (3) tick();
    check("rst_trig", trig, 0);
    check("rst_valid", valid, 0);
    check("rst_timeout", timeout, 0);
    check("rst_busy", busy, 0);
    check("rst_cm", distancia_cm, 8'hFF);
    rst_n = 1'b1;
    repeat (3) tick();
    check("idle_busy", busy, 0);
    check("idle_trig", trig, 0);

    run_meas(580, 8'd10, "w580");
    run_meas(1159, 8'd19, "w1159");
    run_meas(1160, 8'd20, "w1160");
    run_meas(57, 8'd0, "w57");
    run_meas(58, 8'd1, "w58");

    // No echo at all
    pulse_start();
    trig_width(n);
    check("noecho_trig_w", n, 10);
    n = 0;
    while (timeout !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    check("noecho_to_lat", n, 200);
    check("noecho_cm", distancia_cm, 8'hFF);
    check("noecho_valid", valid, 0);
    m = 0;
    while (busy === 1'b1 && m < 400) begin
      tick();
      m++;
      if (valid === 1'b1) check("noecho_stray_valid", valid, 0);
    end
    check("noecho_holdoff", m, 100);

    // Echo stuck high beyond the maximum
    run_meas(580, 8'd10, "pre_long");
    pulse_start();
    trig_width(n);
    repeat (49) tick();
    echo = 1'b1;
    n = 0;
    while (timeout !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    check("long_to_lat", n, 2002);
    check("long_cm", distancia_cm, 8'hFF);
    check("long_valid", valid, 0);
    repeat (300) tick();
    check("long_hold_busy", busy, 1);
    echo = 1'b0;
    m = 0;
    while (busy === 1'b1 && m < 400) begin
      tick();
      m++;
    end
    check("long_holdoff", m, 102);

    // Reset during MEASURE
    run_meas(580, 8'd10, "pre_rst");
    pulse_start();
    trig_width(n);
    repeat (49) tick();
    echo = 1'b1;
    repeat (100) tick();
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mrst_trig", trig, 0);
    check("mrst_cm", distancia_cm, 8'hFF);
    check("mrst_busy", busy, 0);
    check("mrst_valid", valid, 0);
    check("mrst_timeout", timeout, 0);
    echo = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    run_meas(1160, 8'd20, "post_rst");

    // Reset during TRIG drops trig without a clock edge
    pulse_start();
    repeat (3) tick();
    check("trst_trig_hi", trig, 1);
    rst_n = 1'b0;
    #1;
    check("trst_trig", trig, 0);
    check("trst_cm", distancia_cm, 8'hFF);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // start during TRIG and HOLDOFF must be ignored
    rises0 = trig_rises;
    pulse_start();
    repeat (3) tick();
    pulse_start();
    trig_width(n);
    check("ign_trig_w", n, 6);
    repeat (49) tick();
    echo = 1'b1;
    repeat (580) tick();
    echo = 1'b0;
    n = 0;
    while (valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("ign_cm", distancia_cm, 8'd10);
    repeat (10) tick();
    pulse_start();
    m = 0;
    while (busy === 1'b1 && m < 300) begin
      tick();
      m++;
    end
    repeat (20) tick();
    check("ign_idle_busy", busy, 0);
    check("ign_one_trig", trig_rises - rises0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
